data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
Responder end of the pipeline-to-RAM interface. It accepts the address, write data and write strobe driven by the memory/writeback stage, and returns registered read data for loads. After reset it zero-fills a 512x16 synchronous data RAM and holds ready low until the fill completes. It also decodes two memory-mapped I/O words: an LED output register and a synchronized switch input.

Parameters:
ADDR_W, 9, address width; must match addr_mem
DATA_W, 16, word width
DEPTH, 512, number of RAM words (2**ADDR_W)
CLEAR_ON_RESET, 1, 1 = zero-fill the RAM after reset; 0 = go straight to RUN
LED_ADDR, 9'h1FF, MMIO address of the LED register
SW_ADDR, 9'h1FE, MMIO address of the switch input

Ports:
clk  input  1  clock, rising-edge
rst  input  1  reset, synchronous, active-high
addr_mem  input  ADDR_W  word address from the memwrt stage, presented every cycle
wdata_mem  input  DATA_W  store data
write_mem  input  1  store strobe, one word per cycle while high
rdata_mem  output  DATA_W  registered read data for addr_mem of the previous cycle
mem_ready  output  1  high once the RAM is usable
sw_in  input  DATA_W  asynchronous switch inputs
led_out  output  DATA_W  LED register

Behaviour:
- Reset: when rst=1 at a rising edge, the block takes these values at that edge:
  - state <= CLEAR if CLEAR_ON_RESET, else RUN
  - clr_cnt <= 0, rdata_mem <= 0, led_out <= 0, sync flops <= 0
  - mem_ready <= 0 if CLEAR_ON_RESET, else 1
  - RAM contents are not reset directly.
- FSM states are CLEAR and RUN. There is no other state.
- CLEAR state, on each edge:
  - mem[clr_cnt] <= 0 and clr_cnt <= clr_cnt+1.
  - When clr_cnt==DEPTH-1: the last write happens, state <= RUN and mem_ready <= 1.
  - The fill takes exactly DEPTH edges after the first edge with rst=0. mem_ready is therefore high after edge DEPTH.
  - Requests are ignored: write_mem is dropped, rdata_mem is held at 0 and led_out is unchanged.
- rst asserted during CLEAR or RUN restarts the sequence at clr_cnt=0. A partially cleared RAM is legal and must be fully re-cleared.
- RUN state, write decode when write_mem=1 at an edge:
  - addr==LED_ADDR: led_out <= wdata_mem; RAM unchanged.
  - addr==SW_ADDR: write discarded.
  - any other address: mem[addr] <= wdata_mem.
- RUN state, read on every edge regardless of write_mem. rdata_mem <= source(addr_mem), where source is:
  - LED_ADDR: led_out, post-write value
  - SW_ADDR: sw_sync, the 2-flop synchronized sw_in
  - otherwise: mem[addr]
- Read latency is exactly 1 cycle.
- Same-cycle write and read share addr_mem and are write-first: rdata_mem shows the new wdata_mem. This also holds for LED_ADDR.
- Back-to-back writes to the same address: the last write wins, and each cycle's rdata reflects that cycle's write.
- sw_in is synchronized continuously in every state. A change on sw_in is visible on rdata_mem no earlier than 3 edges later (2 synchronizer flops plus the read register).
- Addresses wrap naturally within ADDR_W. No out-of-range condition exists when DEPTH==2**ADDR_W.
- RAM is inferred as a single-port synchronous-write array with a registered read, with no asynchronous read path.

Decomposition:
- Shared package mem_pkg holds:
  - ADDR_W and DATA_W
  - LED_ADDR and SW_ADDR
  - state encoding typedef mem_state_t {CLEAR, RUN}
- One sub-module, sync2: a parameterized-width 2-flop synchronizer with synchronous reset, used for sw_in.

Test Plan:
1. Clear and ready timing:
   - Preload mem[5]=16'hBEEF via backdoor, assert rst for 2 cycles, then release.
   - mem_ready must stay 0 for exactly 512 edges and rise after edge 512.
   - A read of addr 5 afterwards returns 16'h0000.
2. Write then read:
   - In RUN, write addr 9'h010 = 16'h1234 with write_mem=1.
   - On the next cycle present addr 9'h010 with write_mem=0.
   - rdata_mem must equal 16'h1234 one edge later.
3. Write-first:
   - Write addr 9'h020 = 16'hA5A5; rdata_mem after that same edge = 16'hA5A5.
   - The following cycle writes 16'h5A5A to the same address; rdata = 16'h5A5A.
4. MMIO:
   - Write LED_ADDR = 16'h00FF: led_out = 16'h00FF after the edge and the RAM word is untouched.
   - Set sw_in = 16'h0F0F: a read of SW_ADDR returns 16'h0F0F by the 3rd edge, not before.
   - Write SW_ADDR = 16'hFFFF: no effect on rdata_mem or led_out.
5. Requests during clear:
   - During CLEAR drive write_mem=1, addr 9'h030, data 16'h7777.
   - After ready, mem[9'h030] = 0, led_out = 0 and rdata_mem stayed 0 throughout CLEAR.
6. Mid-clear reset:
   - Assert rst at clr_cnt = 200.
   - mem_ready must fall/stay 0 and then rise exactly 512 edges after release.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the data memory responder.
package mem_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;

    localparam logic [ADDR_W-1:0] LED_ADDR = 9'h1FF;
    localparam logic [ADDR_W-1:0] SW_ADDR  = 9'h1FE;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } mem_state_t;

    // Source selected for the read data register on the next edge.
    typedef enum logic [2:0] {
        RD_ZERO  = 3'd0,
        RD_LED   = 3'd1,
        RD_SW    = 3'd2,
        RD_WDATA = 3'd3,
        RD_MEM   = 3'd4
    } rd_src_t;

endpackage

// File: rtl/data_mem_responder_sync2.sv
// Two-flop synchronizer with synchronous active-high reset.
module sync2 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the pipeline-to-RAM interface: zero-fills the data RAM
// after reset, then serves loads/stores plus LED and switch MMIO words.
//
// state | meaning
// CLEAR | zero-filling RAM, one word per edge; requests ignored, ready low
// RUN   | normal operation, write-first reads with 1-cycle latency
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int                     ADDR_W         = mem_pkg::ADDR_W,
    parameter int                     DATA_W         = mem_pkg::DATA_W,
    parameter int                     DEPTH          = 2 ** ADDR_W,
    parameter bit                     CLEAR_ON_RESET = 1'b1,
    parameter logic [ADDR_W-1:0]      LED_ADDR       = mem_pkg::LED_ADDR,
    parameter logic [ADDR_W-1:0]      SW_ADDR        = mem_pkg::SW_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_mem,
    input  logic [DATA_W-1:0] wdata_mem,
    input  logic              write_mem,
    output logic [DATA_W-1:0] rdata_mem,
    output logic              mem_ready,
    input  logic [DATA_W-1:0] sw_in,
    output logic [DATA_W-1:0] led_out
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    mem_state_t        state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic              ready_nxt;
    logic [DATA_W-1:0] led_nxt;
    logic [DATA_W-1:0] sw_sync;
    rd_src_t           rd_src;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [DATA_W-1:0] mem [DEPTH];

    sync2 #(.W(DATA_W)) u_sw_sync (
        .clk (clk),
        .rst (rst),
        .d   (sw_in),
        .q   (sw_sync)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR_ON_RESET ? CLEAR : RUN;
            clr_cnt   <= '0;
            mem_ready <= !CLEAR_ON_RESET;
            led_out   <= '0;
        end else begin
            state     <= state_nxt;
            clr_cnt   <= clr_cnt_nxt;
            mem_ready <= ready_nxt;
            led_out   <= led_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        ready_nxt   = mem_ready;
        led_nxt     = led_out;
        rd_src      = RD_ZERO;
        mem_we      = 1'b0;
        mem_waddr   = addr_mem;
        mem_wdata   = wdata_mem;
        unique case (state)
            CLEAR: begin
                mem_we      = !rst;
                mem_waddr   = clr_cnt;
                mem_wdata   = '0;
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == LAST_ADDR) begin
                    state_nxt = RUN;
                    ready_nxt = 1'b1;
                end
            end
            RUN: begin
                if (write_mem) begin
                    if (addr_mem == LED_ADDR)
                        led_nxt = wdata_mem;
                    else if (addr_mem != SW_ADDR)
                        mem_we = !rst;
                end
                // Shared address makes the read write-first on every path.
                if (addr_mem == LED_ADDR)
                    rd_src = RD_LED;
                else if (addr_mem == SW_ADDR)
                    rd_src = RD_SW;
                else if (write_mem)
                    rd_src = RD_WDATA;
                else
                    rd_src = RD_MEM;
            end
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_mem <= '0;
        end else begin
            unique case (rd_src)
                RD_LED:   rdata_mem <= led_nxt;
                RD_SW:    rdata_mem <= sw_sync;
                RD_WDATA: rdata_mem <= wdata_mem;
                RD_MEM:   rdata_mem <= mem[addr_mem];
                default:  rdata_mem <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  addr_mem;
    logic [15:0] wdata_mem;
    logic        write_mem;
    logic [15:0] rdata_mem;
    logic        mem_ready;
    logic [15:0] sw_in;
    logic [15:0] led_out;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    data_mem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .addr_mem  (addr_mem),
        .wdata_mem (wdata_mem),
        .write_mem (write_mem),
        .rdata_mem (rdata_mem),
        .mem_ready (mem_ready),
        .sw_in     (sw_in),
        .led_out   (led_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [8:0] a, input logic [15:0] d);
        write_mem = we;
        addr_mem  = a;
        wdata_mem = d;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!mem_ready && n < 1000) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        drive(1'b0, 9'h000, 16'h0000);
        sw_in = 16'h0000;
        tick();
        tick();
        rst = 1'b0;
        wait_ready(n);
        drive(1'b1, 9'h1FF, 16'h1234);
        tick();
        drive(1'b0, 9'h000, 16'h0000);
        dut.mem[5] = 16'hBEEF;
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if (mem_ready !== 1'b0 || rdata_mem !== 16'h0000 || led_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_values: ready=%b rdata=%h led=%h, required 0/0000/0000",
                     mem_ready, rdata_mem, led_out);
        end
        rst = 1'b0;
        wait_ready(n);
        vectors++;
        if (n !== 512) begin
            errors++;
            $display("FAIL clear_ready_edges: got %0d edges, required 512", n);
        end
        drive(1'b0, 9'h005, 16'h0000);
        tick();
        vectors++;
        if (rdata_mem !== 16'h0000) begin
            errors++;
            $display("FAIL clear_mem5: got %h, required 0000", rdata_mem);
        end
    endtask

    task automatic test_write_read();
        drive(1'b1, 9'h010, 16'h1234);
        tick();
        drive(1'b0, 9'h010, 16'h0000);
        tick();
        vectors++;
        if (rdata_mem !== 16'h1234) begin
            errors++;
            $display("FAIL write_read: got %h, required 1234", rdata_mem);
        end
        drive(1'b0, 9'h011, 16'h0000);
        tick();
        vectors++;
        if (rdata_mem !== 16'h0000) begin
            errors++;
            $display("FAIL neighbour_read: got %h, required 0000", rdata_mem);
        end
    endtask

    task automatic test_write_first();
        drive(1'b1, 9'h020, 16'hA5A5);
        tick();
        vectors++;
        if (rdata_mem !== 16'hA5A5) begin
            errors++;
            $display("FAIL write_first_1: got %h, required a5a5", rdata_mem);
        end
        drive(1'b1, 9'h020, 16'h5A5A);
        tick();
        vectors++;
        if (rdata_mem !== 16'h5A5A) begin
            errors++;
            $display("FAIL write_first_2: got %h, required 5a5a", rdata_mem);
        end
        drive(1'b0, 9'h020, 16'h0000);
        tick();
        vectors++;
        if (rdata_mem !== 16'h5A5A) begin
            errors++;
            $display("FAIL last_write_wins: got %h, required 5a5a", rdata_mem);
        end
    endtask

    task automatic test_mmio();
        drive(1'b1, 9'h1FF, 16'h00FF);
        tick();
        vectors++;
        if (led_out !== 16'h00FF || rdata_mem !== 16'h00FF || dut.mem[9'h1FF] !== 16'h0000) begin
            errors++;
            $display("FAIL led_write: led=%h rdata=%h ram=%h, required 00ff/00ff/0000",
                     led_out, rdata_mem, dut.mem[9'h1FF]);
        end
        drive(1'b0, 9'h1FE, 16'h0000);
        sw_in = 16'h0F0F;
        tick();
        tick();
        vectors++;
        if (rdata_mem !== 16'h0000) begin
            errors++;
            $display("FAIL sw_too_early: got %h after 2 edges, required 0000", rdata_mem);
        end
        tick();
        vectors++;
        if (rdata_mem !== 16'h0F0F) begin
            errors++;
            $display("FAIL sw_read: got %h after 3 edges, required 0f0f", rdata_mem);
        end
        drive(1'b1, 9'h1FE, 16'hFFFF);
        tick();
        vectors++;
        if (rdata_mem !== 16'h0F0F || led_out !== 16'h00FF || dut.mem[9'h1FE] !== 16'h0000) begin
            errors++;
            $display("FAIL sw_write_discard: rdata=%h led=%h ram=%h, required 0f0f/00ff/0000",
                     rdata_mem, led_out, dut.mem[9'h1FE]);
        end
        drive(1'b0, 9'h000, 16'h0000);
    endtask

    task automatic test_clear_requests();
        int  n;
        bit  rd_bad;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b1, 9'h030, 16'h7777);
        n = 0;
        rd_bad = 1'b0;
        while (!mem_ready && n < 1000) begin
            if (rdata_mem !== 16'h0000) rd_bad = 1'b1;
            tick();
            n++;
        end
        drive(1'b0, 9'h030, 16'h0000);
        vectors++;
        if (rd_bad || n !== 512) begin
            errors++;
            $display("FAIL clear_ignores_rd: rdata_nonzero=%b edges=%0d, required 0/512", rd_bad, n);
        end
        tick();
        vectors++;
        if (rdata_mem !== 16'h0000 || led_out !== 16'h0000) begin
            errors++;
            $display("FAIL clear_ignores_wr: mem30=%h led=%h, required 0000/0000", rdata_mem, led_out);
        end
    endtask

    task automatic test_mid_clear_reset();
        int n;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 200; i++) tick();
        dut.mem[100] = 16'h1111;
        rst = 1'b1;
        tick();
        vectors++;
        if (mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_ready: got %b, required 0", mem_ready);
        end
        rst = 1'b0;
        wait_ready(n);
        vectors++;
        if (n !== 512) begin
            errors++;
            $display("FAIL mid_reset_edges: got %0d edges, required 512", n);
        end
        drive(1'b0, 9'd100, 16'h0000);
        tick();
        vectors++;
        if (rdata_mem !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset_reclear: got %h, required 0000", rdata_mem);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_write_first();
        test_mmio();
        test_clear_requests();
        test_mid_clear_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
